quad_input_conditioner: RTL and testbench

//  Front end for the raw quadrature encoder pins. Synchronises A/B into the clk domain and debounces each channel.

---
 rtl/quad_input_conditioner.sv | 149 ++++++++++++++
 tb/tb_quad_input_conditioner.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_input_conditioner.sv
// quad_input_conditioner: per-encoder pin synchroniser, per-channel debounce and registered step/dir/err strobes.
// Optional feature: define QCOND_ERRCNT_EN to build the saturating err_count; otherwise err_count is tied to 0.
module quad_input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int ERR_WIDTH       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 a_raw,
  input  logic                 b_raw,
  output logic                 a_clean,
  output logic                 b_clean,
  output logic                 step,
  output logic                 dir,
  output logic                 err,
  output logic [ERR_WIDTH-1:0] err_count
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int IW = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [IW-1:0] INIT_LAST = IW'(SYNC_STAGES);
  localparam logic [IW-1:0] INIT_ONE  = IW'(1);

  // Bit 1 carries channel A, bit 0 channel B throughout.
  logic [1:0]    pin_raw;
  logic [1:0]    clean_q, clean_d;
  logic          armed_q, armed_d;
  logic [IW-1:0] init_cnt_q, init_cnt_d;
  logic          step_q, step_d;
  logic          dir_q, dir_d;
  logic          err_q, err_d;

  assign pin_raw = {a_raw, b_raw};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      logic [SYNC_STAGES-1:0] sync_q, sync_d;
      logic [CW-1:0]          cnt_q, cnt_d;
      logic                   pin_s;
      logic                   chan_clean_d;

      assign pin_s = sync_q[SYNC_STAGES-1];

      always_comb begin
        sync_d       = {sync_q[SYNC_STAGES-2:0], pin_raw[gi]};
        cnt_d        = '0;
        chan_clean_d = clean_q[gi];
        // Unarmed: clean tracks the synchroniser so a pin resting high is absorbed silently.
        if (!armed_q) begin
          chan_clean_d = pin_s;
        end else if (pin_s != clean_q[gi]) begin
          if (cnt_q == CNT_LAST) begin
            chan_clean_d = pin_s;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          sync_q <= '0;
          cnt_q  <= '0;
        end else begin
          sync_q <= sync_d;
          cnt_q  <= cnt_d;
        end
      end

      assign clean_d[gi] = chan_clean_d;
    end
  endgenerate

  logic [1:0] changed;
  assign changed = clean_d ^ clean_q;

  always_comb begin
    armed_d    = armed_q;
    init_cnt_d = init_cnt_q;
    step_d     = 1'b0;
    err_d      = 1'b0;
    dir_d      = dir_q;
    if (!armed_q) begin
      if (init_cnt_q == INIT_LAST) begin
        armed_d = 1'b1;
      end else begin
        init_cnt_d = init_cnt_q + INIT_ONE;
      end
    end else if (changed == 2'b11) begin
      err_d = 1'b1;
    end else if (changed != 2'b00) begin
      step_d = 1'b1;
      // Forward transitions are exactly those where new A differs from old B.
      dir_d  = clean_q[0] ^ clean_d[1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clean_q    <= 2'b00;
      armed_q    <= 1'b0;
      init_cnt_q <= '0;
      step_q     <= 1'b0;
      dir_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      clean_q    <= clean_d;
      armed_q    <= armed_d;
      init_cnt_q <= init_cnt_d;
      step_q     <= step_d;
      dir_q      <= dir_d;
      err_q      <= err_d;
    end
  end

  assign a_clean = clean_q[1];
  assign b_clean = clean_q[0];
  assign step    = step_q;
  assign dir     = dir_q;
  assign err     = err_q;

`ifdef QCOND_ERRCNT_EN
  logic [ERR_WIDTH-1:0] err_count_q, err_count_d;

  // Counts on err_d so the count moves on the same edge as the err pulse.
  always_comb begin
    err_count_d = err_count_q;
    if (err_d && (err_count_q != {ERR_WIDTH{1'b1}})) begin
      err_count_d = err_count_q + ERR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_count_q <= '0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_quad_input_conditioner.sv
// Bench for quad_input_conditioner (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, ERR_WIDTH=2): directed scenarios plus
// randomized pins checked against a window-based reference model of the debounce and quadrature rules.
module tb_quad_input_conditioner;

  localparam int SYNC    = 2;
  localparam int DEB     = 4;
  localparam int EW      = 2;
  localparam int ERR_MAX = (1 << EW) - 1;
`ifdef QCOND_ERRCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_raw = 1'b0;
  logic          b_raw = 1'b0;
  logic          a_clean, b_clean, step, dir, err;
  logic [EW-1:0] err_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  quad_input_conditioner #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .ERR_WIDTH      (EW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_raw    (a_raw),
    .b_raw    (b_raw),
    .a_clean  (a_clean),
    .b_clean  (b_clean),
    .step     (step),
    .dir      (dir),
    .err      (err),
    .err_count(err_count)
  );

  // Reference model: raw pin history since reset release, evaluated with window rules.
  bit       ha[$];
  bit       hb[$];
  int       m_k = 0;
  bit [1:0] m_clean = 2'b00;
  bit       m_step = 1'b0;
  bit       m_dir = 1'b0;
  bit       m_err = 1'b0;
  int       m_errcnt = 0;

  // Synchroniser output seen just before edge j (edges numbered from 1 after release).
  function automatic bit s_at(int ch, int j);
    int idx;
    idx = j - SYNC - 1;
    if (idx < 0) return 1'b0;
    return (ch == 1) ? ha[idx] : hb[idx];
  endfunction

  // Position in the forward Gray cycle 00 -> 10 -> 11 -> 01.
  function automatic int gray_idx(bit [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic model_edge(input bit r, input bit a, input bit b);
    bit [1:0] nc;
    bit [1:0] ch;
    bit       flip;
    if (!r) begin
      m_k = 0; ha.delete(); hb.delete();
      m_clean = 2'b00; m_step = 1'b0; m_dir = 1'b0; m_err = 1'b0; m_errcnt = 0;
      return;
    end
    m_k++;
    ha.push_back(a);
    hb.push_back(b);
    nc = m_clean;
    for (int c = 0; c < 2; c++) begin
      if (m_k <= SYNC + 1) begin
        nc[c] = s_at(c, m_k);
      end else begin
        // Accept a new level once the last DEB armed samples all disagree with clean.
        flip = 1'b1;
        for (int i = 0; i < DEB; i++) begin
          if ((m_k - i) < SYNC + 2 || s_at(c, m_k - i) == m_clean[c]) flip = 1'b0;
        end
        if (flip) nc[c] = ~m_clean[c];
      end
    end
    m_step = 1'b0;
    m_err  = 1'b0;
    if (m_k > SYNC + 1) begin
      ch = nc ^ m_clean;
      if (ch == 2'b11) begin
        m_err = 1'b1;
        if (CNT_EN && m_errcnt < ERR_MAX) m_errcnt++;
      end else if (ch != 2'b00) begin
        m_step = 1'b1;
        m_dir  = (((gray_idx(nc) - gray_idx(m_clean)) + 4) % 4) == 1;
      end
    end
    m_clean = nc;
  endtask

  task automatic tick(input bit r, input bit a, input bit b);
    rst_n = r; a_raw = a; b_raw = b;
    @(posedge clk);
    model_edge(r, a, b);
    #1;
  endtask

  task automatic settle(input logic [1:0] p);
    repeat (2) tick(1'b0, p[1], p[0]);
    repeat (8) tick(1'b1, p[1], p[0]);
  endtask

  task automatic hold(input logic [1:0] p, input int n, output int steps, output int errs, output int fwd);
    steps = 0; errs = 0; fwd = 0;
    for (int i = 0; i < n; i++) begin
      tick(1'b1, p[1], p[0]);
      if (step === 1'b1) begin
        steps++;
        if (dir === 1'b1) fwd++;
      end
      if (err === 1'b1) errs++;
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      total++;
      if ({a_clean, b_clean, step, dir, err, err_count} !== 7'b0) begin
        bad++;
        $display("FAIL reset_state: got %b expected 0000000", {a_clean, b_clean, step, dir, err, err_count});
      end
    end
    $display("test_reset: done");
  endtask

  task automatic test_pins_high_reset;
    repeat (3) tick(1'b0, 1'b1, 1'b1);
    for (int e = 1; e <= 8; e++) begin
      tick(1'b1, 1'b1, 1'b1);
      if (e == 3) begin
        total++;
        if ({a_clean, b_clean} !== 2'b11) begin
          bad++;
          $display("FAIL high_reset_clean: got %b expected 11", {a_clean, b_clean});
        end
      end
      total++;
      if ({step, err} !== 2'b00) begin
        bad++;
        $display("FAIL high_reset_strobe edge %0d: step/err %b expected 00", e, {step, err});
      end
    end
    $display("test_pins_high_reset: done");
  endtask

  task automatic test_single_step;
    int n;
    repeat (2) tick(1'b0, 1'b0, 1'b0);
    repeat (5) tick(1'b1, 1'b0, 1'b0);
    n = 0;
    while (n < 13) begin
      n++;
      tick(1'b1, 1'b1, 1'b0);
      if (a_clean === 1'b1) break;
    end
    total++;
    if (n != 6) begin
      bad++;
      $display("FAIL step_latency: a_clean rose after %0d edges expected 6", n);
    end
    total++;
    if ({step, dir, err} !== 3'b110) begin
      bad++;
      $display("FAIL step_strobe: step/dir/err %b expected 110", {step, dir, err});
    end
    tick(1'b1, 1'b1, 1'b0);
    total++;
    if (step !== 1'b0) begin
      bad++;
      $display("FAIL step_width: step %b expected 0", step);
    end
    $display("test_single_step: latency %0d edges", n);
  endtask

  task automatic test_glitch;
    int n;
    settle(2'b00);
    repeat (3) tick(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b0, 1'b0);
      total++;
      if ({a_clean, step} !== 2'b00) begin
        bad++;
        $display("FAIL glitch_reject cycle %0d: a_clean/step %b expected 00", i, {a_clean, step});
      end
    end
    // A full-length raise afterwards must still need the whole debounce window.
    n = 0;
    while (n < 13) begin
      n++;
      tick(1'b1, 1'b1, 1'b0);
      if (a_clean === 1'b1) break;
    end
    total++;
    if (n != 6) begin
      bad++;
      $display("FAIL glitch_counter_clear: raise took %0d edges expected 6", n);
    end
    $display("test_glitch: done");
  endtask

  task automatic test_sequences;
    logic [1:0] fwd_seq[4];
    logic [1:0] rev_seq[4];
    int s, e, f, ts, te, tf;
    fwd_seq = '{2'b10, 2'b11, 2'b01, 2'b00};
    rev_seq = '{2'b01, 2'b11, 2'b10, 2'b00};
    settle(2'b00);
    ts = 0; te = 0; tf = 0;
    for (int i = 0; i < 4; i++) begin
      hold(fwd_seq[i], 10, s, e, f);
      ts += s; te += e; tf += f;
    end
    total++;
    if (ts != 4 || tf != 4 || te != 0) begin
      bad++;
      $display("FAIL forward_seq: steps=%0d fwd=%0d errs=%0d expected 4 4 0", ts, tf, te);
    end
    ts = 0; te = 0; tf = 0;
    for (int i = 0; i < 4; i++) begin
      hold(rev_seq[i], 10, s, e, f);
      ts += s; te += e; tf += f;
    end
    total++;
    if (ts != 4 || tf != 0 || te != 0) begin
      bad++;
      $display("FAIL reverse_seq: steps=%0d fwd=%0d errs=%0d expected 4 0 0", ts, tf, te);
    end
    $display("test_sequences: done");
  endtask

  task automatic test_err;
    int s, e, f;
    logic [EW-1:0] exp_cnt;
    exp_cnt = CNT_EN ? 2'd1 : 2'd0;
    settle(2'b00);
    hold(2'b10, 10, s, e, f);
    hold(2'b01, 12, s, e, f);
    total++;
    if (e != 1 || s != 0) begin
      bad++;
      $display("FAIL err_pulse: errs=%0d steps=%0d expected 1 0", e, s);
    end
    total++;
    if (dir !== 1'b1) begin
      bad++;
      $display("FAIL err_dir_hold: dir %b expected 1", dir);
    end
    total++;
    if (err_count !== exp_cnt) begin
      bad++;
      $display("FAIL err_count_one: got %0d expected %0d", err_count, exp_cnt);
    end
    $display("test_err: done");
  endtask

  task automatic test_reset_mid;
    int s, e, f, te;
    logic [EW-1:0] exp_cnt;
    settle(2'b00);
    hold(2'b11, 10, s, e, f);
    hold(2'b01, 10, s, e, f);
    repeat (4) tick(1'b1, 1'b1, 1'b1);
    total++;
    if ({a_clean, b_clean, dir} !== 3'b011) begin
      bad++;
      $display("FAIL pre_reset_state: a/b/dir %b expected 011", {a_clean, b_clean, dir});
    end
    tick(1'b0, 1'b1, 1'b1);
    total++;
    if ({a_clean, b_clean, step, dir, err, err_count} !== 7'b0) begin
      bad++;
      $display("FAIL reset_mid: got %b expected 0000000", {a_clean, b_clean, step, dir, err, err_count});
    end
    repeat (8) tick(1'b1, 1'b0, 1'b0);
    te = 0;
    for (int i = 0; i < 5; i++) begin
      hold((i % 2 == 0) ? 2'b11 : 2'b00, 8, s, e, f);
      te += e;
    end
    exp_cnt = CNT_EN ? 2'd3 : 2'd0;
    total++;
    if (te != 5) begin
      bad++;
      $display("FAIL err_events: errs=%0d expected 5", te);
    end
    total++;
    if (err_count !== exp_cnt) begin
      bad++;
      $display("FAIL err_count_sat: got %0d expected %0d", err_count, exp_cnt);
    end
    $display("test_reset_mid: done");
  endtask

  task automatic test_random;
    int cyc, len;
    logic [1:0] p;
    cyc = 0;
    while (cyc < 800) begin
      if ($urandom_range(0, 39) == 0) begin
        len = $urandom_range(1, 2);
        p = 2'($urandom_range(0, 3));
        for (int i = 0; i < len; i++) begin
          tick(1'b0, p[1], p[0]);
          cyc++;
        end
      end else begin
        len = $urandom_range(1, 12);
        p = 2'($urandom_range(0, 3));
        for (int i = 0; i < len; i++) begin
          tick(1'b1, p[1], p[0]);
          cyc++;
          total++;
          if ({a_clean, b_clean, step, dir, err, err_count} !==
              {m_clean, m_step, m_dir, m_err, EW'(m_errcnt)}) begin
            bad++;
            $display("FAIL random_model cycle %0d: got %b expected %b", cyc,
                     {a_clean, b_clean, step, dir, err, err_count},
                     {m_clean, m_step, m_dir, m_err, EW'(m_errcnt)});
          end
        end
      end
    end
    $display("test_random: %0d cycles", cyc);
  endtask

  initial begin
    test_reset();
    test_pins_high_reset();
    test_single_step();
    test_glitch();
    test_sequences();
    test_err();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
